// File: rtl/apb_master_bridge_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master_bridge_pkg : FSM states, strobe width and fault codes shared
//                         by the APB bridge and its address decoder
// Revision: 1.0
// ----------------------------------------------------------------------------
package apb_master_bridge_pkg;

  localparam int APB_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_SLVERR  = 2'd1,
    FAULT_TIMEOUT = 2'd2
  } apb_fault_t;

  // Reads never present byte strobes on the bus.
  function automatic logic [APB_STRB_W-1:0] apb_strb(input logic                  write,
                                                     input logic [APB_STRB_W-1:0] strb);
    return write ? strb : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master_bridge : core load/store channel to APB SETUP/ACCESS master,
//                     one outstanding transfer, perr/timeout become errors
// Revision: 1.0
// ----------------------------------------------------------------------------
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  input  logic [APB_STRB_W-1:0] req_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [APB_STRB_W-1:0] pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  perr
);

  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int              CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_t            state_q, state_d;
  apb_fault_t            fault_q, fault_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [APB_STRB_W-1:0] pstb_q, pstb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic w_done;
  logic w_expired;

  // perr alone also completes: the decoder flags unmapped addresses without pready.
  assign w_done    = pready | perr;
  assign w_expired = TIMEOUT_EN && !w_done && (cnt_q == CNT_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (w_done || w_expired) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    psel      = (state_q == SETUP) || (state_q == ACCESS);
    penable   = (state_q == ACCESS);
    rsp_valid = (state_q == RESP);
  end

  always_comb begin
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    paddr_d  = paddr_q;
    pdata_d  = pdata_q;
    pwrite_d = pwrite_q;
    pstb_d   = pstb_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pdata_d  = req_wdata;
          pwrite_d = req_write;
          pstb_d   = apb_strb(req_write, req_strb);
        end
      end
      SETUP: cnt_d = '0;
      ACCESS: begin
        if (w_done) begin
          rdata_d = (!pwrite_q && pready && !perr) ? prdata : '0;
          fault_d = perr ? FAULT_SLVERR : FAULT_NONE;
        end else if (w_expired) begin
          rdata_d = '0;
          fault_d = FAULT_TIMEOUT;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q    <= '0;
      fault_q  <= FAULT_NONE;
      rdata_q  <= '0;
      paddr_q  <= '0;
      pdata_q  <= '0;
      pwrite_q <= 1'b0;
      pstb_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      paddr_q  <= paddr_d;
      pdata_q  <= pdata_d;
      pwrite_q <= pwrite_d;
      pstb_q   <= pstb_d;
    end
  end

  assign paddr     = paddr_q;
  assign pdata     = pdata_q;
  assign pwrite    = pwrite_q;
  assign pstb      = pstb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = (fault_q != FAULT_NONE);

endmodule
`default_nettype wire
